// File: rtl/key_redraw_scheduler.sv
// ---------------------------------------------------------------------------
// key_redraw_scheduler
//
// Sequences partial redraws of the on-screen piano for a 160x120 VGA adapter.
// Each change in a key's pressed level raises a redraw request for that key.
// A round-robin arbiter grants one request at a time. The granted key's
// bounding box, taken from an external geometry LUT, is scanned in raster
// order through the shared sprite ROM. Pixels then go to the adapter at one
// per cycle, aligned with the ROM read latency.
//
// Ports
//   CLOCK_50     in   system clock, all logic on the rising edge
//   reset        in   synchronous active-high reset
//   key_state    in   current pressed level per key (1 = pressed)
//   sel_key      out  granted key index; drives the external geometry LUT
//   geom_x0/y0   in   box top-left corner for sel_key (combinational LUT)
//   geom_w/h     in   box width / height in pixels
//   rom_addr     out  sprite ROM address, SCR_W*y + x
//   rom_pressed  out  1 = pressed-sprite ROM, 0 = unpressed-sprite ROM
//   rom_colour   in   ROM data, valid ROM_LAT cycles after rom_addr
//   vga_x/vga_y  out  pixel coordinate to the adapter
//   vga_colour   out  pixel colour (ROM data passed straight through)
//   vga_plot     out  pixel write strobe
//   busy         out  high in every state except IDLE
// ---------------------------------------------------------------------------
module key_redraw_scheduler #(
   parameter int NKEYS   = 24,
   parameter int ROM_LAT = 2,
   parameter int SCR_W   = 160,
   parameter int SCR_H   = 120
) (
   input  logic             CLOCK_50,
   input  logic             reset,
   input  logic [NKEYS-1:0] key_state,
   output logic [4:0]       sel_key,
   input  logic [7:0]       geom_x0,
   input  logic [6:0]       geom_y0,
   input  logic [7:0]       geom_w,
   input  logic [6:0]       geom_h,
   output logic [14:0]      rom_addr,
   output logic             rom_pressed,
   input  logic [2:0]       rom_colour,
   output logic [7:0]       vga_x,
   output logic [6:0]       vga_y,
   output logic [2:0]       vga_colour,
   output logic             vga_plot,
   output logic             busy
);

   localparam int          DW     = $clog2(ROM_LAT) + 1;
   localparam logic [8:0]  SCR_W9 = 9'(SCR_W);
   localparam logic [8:0]  SCR_H9 = 9'(SCR_H);
   localparam logic [14:0] SCR_W15 = 15'(SCR_W);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SCAN,
      S_DRAIN
   } state_t;

   state_t           r_state;
   logic [NKEYS-1:0] r_prev;
   logic [NKEYS-1:0] r_pending;
   logic [4:0]       r_sel;
   logic [4:0]       r_rr_ptr;
   logic [7:0]       r_x0;
   logic [7:0]       r_w;
   logic [6:0]       r_h;
   logic [8:0]       r_cx;
   logic [8:0]       r_cy;
   logic [7:0]       r_col;
   logic [6:0]       r_row;
   logic [DW-1:0]    r_drain;
   logic [14:0]      r_rom_addr;
   logic             r_rom_pressed;

   // Pixel pipeline: stage 0 is aligned with rom_addr, stage ROM_LAT with rom_colour.
   logic [7:0]       r_px [0:ROM_LAT];
   logic [6:0]       r_py [0:ROM_LAT];
   logic             r_pv [0:ROM_LAT];

   logic [NKEYS-1:0] w_edge;
   logic [NKEYS-1:0] w_clr_mask;
   logic             w_grant_vld;
   logic [4:0]       w_grant_idx;
   logic [4:0]       w_rr_next;
   logic             w_last_col;
   logic             w_last_row;
   logic             w_pix_valid;
   logic [14:0]      w_addr;

   assign w_edge = key_state ^ r_prev;

   // Round-robin search: lowest index at or above rr_ptr, wrapping modulo NKEYS.
   // Walking the offsets from high to low lets the smallest offset win.
   always_comb begin
      int j;
      // NOTE: every variable gets a default first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      j           = 0;
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      for (int i = NKEYS - 1; i >= 0; i--) begin
         j = int'(r_rr_ptr) + i;
         if (j >= NKEYS) j = j - NKEYS;
         if (r_pending[5'(j)]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = 5'(j);
         end
      end
   end

   assign w_rr_next = (w_grant_idx == 5'(NKEYS - 1)) ? 5'd0 : w_grant_idx + 5'd1;

   always_comb begin
      w_clr_mask = '0;
      if (r_state == S_LOAD) w_clr_mask[r_sel] = 1'b1;
   end

   // w and h are at least 1 whenever SCAN is entered, so the minus-one never wraps.
   assign w_last_col  = (r_col == r_w - 8'd1);
   assign w_last_row  = (r_row == r_h - 7'd1);
   // 9-bit coordinates keep x0+w-1 and y0+h-1 from wrapping into the visible area.
   assign w_pix_valid = (r_cx < SCR_W9) && (r_cy < SCR_H9);
   assign w_addr      = 15'(r_cy) * SCR_W15 + 15'(r_cx);

   // NOTE: all state is updated with non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_prev        <= '0;
         r_pending     <= '0;
         r_sel         <= '0;
         r_rr_ptr      <= '0;
         r_x0          <= '0;
         r_w           <= '0;
         r_h           <= '0;
         r_cx          <= '0;
         r_cy          <= '0;
         r_col         <= '0;
         r_row         <= '0;
         r_drain       <= '0;
         r_rom_addr    <= '0;
         r_rom_pressed <= 1'b0;
         // NOTE: the pipeline is a handful of control flops, not a RAM, so it is
         // reset; this is what drops in-flight pixels when a scan is aborted.
         for (int k = 0; k <= ROM_LAT; k++) begin
            r_px[k] <= '0;
            r_py[k] <= '0;
            r_pv[k] <= 1'b0;
         end
      end else begin
         r_prev <= key_state;
         // A toggle in the LOAD cycle itself wins over the clear.
         r_pending <= (r_pending & ~w_clr_mask) | w_edge;

         r_pv[0] <= (r_state == S_SCAN) && w_pix_valid;
         r_px[0] <= r_cx[7:0];
         r_py[0] <= r_cy[6:0];
         for (int k = 1; k <= ROM_LAT; k++) begin
            r_px[k] <= r_px[k-1];
            r_py[k] <= r_py[k-1];
            r_pv[k] <= r_pv[k-1];
         end

         case (r_state)
            S_IDLE: begin
               if (w_grant_vld) begin
                  r_sel    <= w_grant_idx;
                  r_rr_ptr <= w_rr_next;
                  r_state  <= S_LOAD;
               end
            end

            S_LOAD: begin
               r_x0          <= geom_x0;
               r_w           <= geom_w;
               r_h           <= geom_h;
               r_cx          <= {1'b0, geom_x0};
               r_cy          <= {2'b00, geom_y0};
               r_col         <= '0;
               r_row         <= '0;
               r_rom_pressed <= key_state[r_sel];
               if (geom_w == 8'd0 || geom_h == 7'd0) r_state <= S_IDLE;
               else                                  r_state <= S_SCAN;
            end

            S_SCAN: begin
               r_rom_addr <= w_addr;
               if (w_last_col) begin
                  r_col <= '0;
                  r_cx  <= {1'b0, r_x0};
                  if (w_last_row) begin
                     r_drain <= '0;
                     r_state <= S_DRAIN;
                  end else begin
                     r_row <= r_row + 7'd1;
                     r_cy  <= r_cy + 9'd1;
                  end
               end else begin
                  r_col <= r_col + 8'd1;
                  r_cx  <= r_cx + 9'd1;
               end
            end

            S_DRAIN: begin
               if (r_drain == DW'(ROM_LAT - 1)) r_state <= S_IDLE;
               else                             r_drain <= r_drain + DW'(1);
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign sel_key     = r_sel;
   assign rom_addr    = r_rom_addr;
   assign rom_pressed = r_rom_pressed;
   assign vga_x       = r_px[ROM_LAT];
   assign vga_y       = r_py[ROM_LAT];
   assign vga_plot    = r_pv[ROM_LAT];
   assign vga_colour  = rom_colour;
   assign busy        = (r_state != S_IDLE);

endmodule
